pc_sequencer: RTL and testbench

Parametrised next-PC and control-flow sequencer for the MIPS core. It replaces the inline PC update in the core with a dedicated block that holds the word-addressed program counter, resolves J / JAL / JR / conditional branch, and supports pipeline stalls and a halt instruction. It also maintains a circular return-address stack (RAS) that is pushed on JAL and popped on `JR $31`; the RAS feeds a mismatch monitor used for return-prediction bring-up.

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC and control-flow sequencer: word-addressed PC, J/JAL/JR/branch resolution,
// stall and halt handling, plus a circular return-address stack with a mismatch monitor.
module pc_sequencer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       RAS_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        HALT_OPCODE = 6'h3F
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs,
    input  logic [ADDR_W-1:0] rs_content,
    input  logic [25:0]       address,
    input  logic [15:0]       immediate,
    input  logic              branch_en,
    input  logic              branch_cond,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] link_data,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_mismatch,
    output logic [7:0]        mismatch_count
);

    localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(RAS_DEPTH);
    localparam logic [5:0]       OP_SPECIAL = 6'h00;
    localparam logic [5:0]       OP_J       = 6'h02;
    localparam logic [5:0]       OP_JAL     = 6'h03;
    localparam logic [5:0]       FN_JR      = 6'h08;
    localparam logic [4:0]       RA_REG     = 5'd31;

    typedef enum logic [2:0] {
        FLOW_SEQ,
        FLOW_HOLD,
        FLOW_JUMP,
        FLOW_JAL,
        FLOW_JR,
        FLOW_BRANCH
    } flow_e;

    flow_e             flow;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  pop_ptr;
    logic [PTR_W:0]    ras_count;
    logic [PTR_W:0]    ras_count_next;
    logic [ADDR_W-1:0] popped;
    logic              advance;
    logic              do_push;
    logic              do_pop;
    logic              mismatch_hit;

    assign pc_plus1      = pc + ADDR_W'(1);
    assign link_data     = pc_plus1;
    assign branch_target = pc_plus1 + ADDR_W'($signed(immediate));

    // Jumps keep the upper PC bits only when the PC is wider than the target field.
    generate
        if (ADDR_W > 26) begin : g_wide_jump
            assign jump_target = {pc_plus1[ADDR_W-1:26], address};
        end else begin : g_narrow_jump
            assign jump_target = address[ADDR_W-1:0];
        end
    endgenerate

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        flow = FLOW_SEQ;
        if (halted || opcode == HALT_OPCODE) begin
            flow = FLOW_HOLD;
        end else if (opcode == OP_J) begin
            flow = FLOW_JUMP;
        end else if (opcode == OP_JAL) begin
            flow = FLOW_JAL;
        end else if (opcode == OP_SPECIAL && funct == FN_JR) begin
            flow = FLOW_JR;
        end else if (branch_en && branch_cond) begin
            flow = FLOW_BRANCH;
        end
    end

    always_comb begin
        pc_next = pc_plus1;
        case (flow)
            FLOW_HOLD:   pc_next = pc;
            FLOW_JUMP:   pc_next = jump_target;
            FLOW_JAL:    pc_next = jump_target;
            FLOW_JR:     pc_next = rs_content;
            FLOW_BRANCH: pc_next = branch_target;
            default:     pc_next = pc_plus1;
        endcase
    end

    // The RAS only observes control flow; the architectural target is always rs_content.
    assign advance      = reset_n && !halted && !stall;
    assign do_push      = advance && (flow == FLOW_JAL);
    assign do_pop       = advance && (flow == FLOW_JR) && (rs == RA_REG) && (ras_count != '0);
    assign pop_ptr      = ras_ptr - PTR_W'(1);
    assign popped       = ras_mem[pop_ptr];
    assign mismatch_hit = do_pop && (popped != rs_content);

    always_comb begin
        ras_count_next = ras_count;
        if (do_push && ras_count != FULL_COUNT) begin
            ras_count_next = ras_count + (PTR_W + 1)'(1);
        end else if (do_pop) begin
            ras_count_next = ras_count - (PTR_W + 1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            ras_ptr        <= '0;
            ras_count      <= '0;
            halted         <= 1'b0;
            ras_empty      <= 1'b1;
            ras_full       <= 1'b0;
            ras_overflow   <= 1'b0;
            ras_mismatch   <= 1'b0;
            mismatch_count <= '0;
        end else if (halted || stall) begin
            ras_mismatch <= 1'b0;
        end else begin
            pc           <= pc_next;
            ras_count    <= ras_count_next;
            ras_empty    <= (ras_count_next == '0);
            ras_full     <= (ras_count_next == FULL_COUNT);
            ras_mismatch <= mismatch_hit;
            if (flow == FLOW_HOLD) begin
                halted <= 1'b1;
            end
            if (do_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_count == FULL_COUNT) begin
                    ras_overflow <= 1'b1;
                end
            end else if (do_pop) begin
                ras_ptr <= pop_ptr;
            end
            if (mismatch_hit && mismatch_count != 8'hFF) begin
                mismatch_count <= mismatch_count + 8'd1;
            end
        end
    end

    // NOTE: the stack storage is not reset; ras_count alone decides which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            ras_mem[ras_ptr] <= link_data;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based return-stack model checked every cycle,
// directed scenarios with literal expectations, and a randomized control-flow phase.
module tb_pc_sequencer;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h10;
    localparam logic [5:0]  HALT  = 6'h3F;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall = 1'b0;
    logic [5:0]    opcode = 6'h20;
    logic [5:0]    funct = 6'h00;
    logic [4:0]    rs = 5'd0;
    logic [AW-1:0] rs_content = '0;
    logic [25:0]   address = '0;
    logic [15:0]   immediate = '0;
    logic          branch_en = 1'b0;
    logic          branch_cond = 1'b0;
    logic [AW-1:0] pc, pc_next, link_data;
    logic          halted, ras_empty, ras_full, ras_overflow, ras_mismatch;
    logic [7:0]    mismatch_count;

    pc_sequencer #(
        .ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC), .HALT_OPCODE(HALT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .opcode(opcode), .funct(funct),
        .rs(rs), .rs_content(rs_content), .address(address), .immediate(immediate),
        .branch_en(branch_en), .branch_cond(branch_cond), .pc(pc), .pc_next(pc_next),
        .link_data(link_data), .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_mismatch(ras_mismatch), .mismatch_count(mismatch_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the return stack is a bounded queue, newest entry at the back.
    logic [31:0] m_pc;
    bit          m_halted, m_overflow, m_mismatch;
    int          m_mcount;
    logic [31:0] m_ras[$];
    logic [31:0] m_nxt, m_top;

    function automatic logic [31:0] exp_next();
        logic [31:0] p1;
        p1 = m_pc + 32'd1;
        if (m_halted || opcode == HALT) return m_pc;
        if (opcode == 6'h02 || opcode == 6'h03) return {p1[31:26], address};
        if (opcode == 6'h00 && funct == 6'h08) return rs_content;
        if (branch_en && branch_cond) return p1 + {{16{immediate[15]}}, immediate};
        return p1;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            m_pc = RPC;
            m_halted = 1'b0;
            m_overflow = 1'b0;
            m_mismatch = 1'b0;
            m_mcount = 0;
            m_ras.delete();
        end else if (m_halted || stall) begin
            m_mismatch = 1'b0;
        end else begin
            m_nxt = exp_next();
            m_mismatch = 1'b0;
            if (opcode == 6'h03) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_overflow = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd1);
            end else if (opcode == 6'h00 && funct == 6'h08 && rs == 5'd31 && m_ras.size() > 0) begin
                m_top = m_ras.pop_back();
                if (m_top != rs_content) begin
                    m_mismatch = 1'b1;
                    if (m_mcount < 255) m_mcount++;
                end
            end
            if (opcode == HALT) m_halted = 1'b1;
            m_pc = m_nxt;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("pc", pc, m_pc);
            check("pc_next", pc_next, exp_next());
            check("link_data", link_data, m_pc + 32'd1);
            check("halted", 32'(halted), 32'(m_halted));
            check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            check("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
            check("ras_overflow", 32'(ras_overflow), 32'(m_overflow));
            check("ras_mismatch", 32'(ras_mismatch), 32'(m_mismatch));
            check("mismatch_count", 32'(mismatch_count), 32'(m_mcount));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                         input logic [31:0] rc, input logic [25:0] ad, input logic [15:0] im,
                         input logic be, input logic bc, input logic st);
        opcode = op; funct = fn; rs = r; rs_content = rc; address = ad;
        immediate = im; branch_en = be; branch_cond = bc; stall = st;
    endtask

    task automatic idle();
        drive(6'h20, 6'h00, 5'd0, 32'h0, 26'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jump(input logic [5:0] op, input logic [25:0] ad);
        drive(op, 6'h00, 5'd0, 32'h0, ad, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jr(input logic [4:0] r, input logic [31:0] rc);
        drive(6'h00, 6'h08, r, rc, 26'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic branch(input logic [15:0] im, input logic bc);
        drive(6'h04, 6'h00, 5'd0, 32'h0, 26'h0, im, 1'b1, bc, 1'b0);
    endtask

    logic [31:0] returns [4] = '{32'h401, 32'h301, 32'h201, 32'h101};

    initial begin
        // Reset, then idle counting from RESET_PC.
        idle();
        reset_n = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        reset_n = 1'b1;
        check("rst_pc", pc, 32'h10);
        check("rst_link", link_data, 32'h11);
        check("rst_pc_next", pc_next, 32'h11);
        check("rst_empty", 32'(ras_empty), 32'd1);
        check("rst_full", 32'(ras_full), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mcount", 32'(mismatch_count), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("idle_pc", pc, 32'h10 + 32'(i));
        end

        // Taken and not-taken branch from pc = 5.
        jump(6'h02, 26'd5);
        tick();
        check("j_pc", pc, 32'd5);
        branch(16'hFFFD, 1'b1);
        #1;
        check("br_taken_next", pc_next, 32'd3);
        tick();
        check("br_taken_pc", pc, 32'd3);
        jump(6'h02, 26'd5);
        tick();
        branch(16'hFFFD, 1'b0);
        tick();
        check("br_not_taken_pc", pc, 32'd6);

        // JAL then matching return.
        jump(6'h02, 26'd7);
        tick();
        jump(6'h03, 26'h40);
        #1;
        check("jal_link", link_data, 32'd8);
        tick();
        check("jal_pc", pc, 32'h40);
        check("jal_not_empty", 32'(ras_empty), 32'd0);
        jr(5'd31, 32'd8);
        tick();
        check("ret_pc", pc, 32'd8);
        check("ret_no_mismatch", 32'(ras_mismatch), 32'd0);
        check("ret_empty", 32'(ras_empty), 32'd1);

        // Five calls overflow the four-deep stack; four correct returns, then an empty return.
        for (int i = 1; i <= 5; i++) begin
            jump(6'h03, 26'(32'h100 * i));
            tick();
            if (i == 4) begin
                check("full_after_4", 32'(ras_full), 32'd1);
                check("no_ovf_after_4", 32'(ras_overflow), 32'd0);
            end
        end
        check("ovf_after_5", 32'(ras_overflow), 32'd1);
        check("full_after_5", 32'(ras_full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            jr(5'd31, returns[i]);
            tick();
        end
        check("returns_pc", pc, 32'h101);
        check("returns_mcount", 32'(mismatch_count), 32'd0);
        check("returns_empty", 32'(ras_empty), 32'd1);
        jr(5'd31, 32'h50);
        tick();
        check("empty_ret_pc", pc, 32'h50);
        check("empty_ret_mm", 32'(ras_mismatch), 32'd0);

        // Mispredicted return pulses once and counts; many more saturate the counter.
        jump(6'h03, 26'h60);
        tick();
        jr(5'd31, 32'h77);
        tick();
        check("mm_pulse", 32'(ras_mismatch), 32'd1);
        check("mm_count1", 32'(mismatch_count), 32'd1);
        check("mm_pc", pc, 32'h77);
        idle();
        tick();
        check("mm_pulse_end", 32'(ras_mismatch), 32'd0);
        for (int i = 0; i < 300; i++) begin
            jump(6'h03, 26'(32'h1000 + 2 * i));
            tick();
            jr(5'd31, 32'hDEAD_0000 + 32'(4 * i));
            tick();
        end
        check("mm_saturated", 32'(mismatch_count), 32'd255);

        // PC wrap-around and a negative branch below zero.
        jr(5'd5, 32'hFFFF_FFFF);
        tick();
        check("wrap_top", pc, 32'hFFFF_FFFF);
        idle();
        #1;
        check("wrap_next", pc_next, 32'h0);
        tick();
        check("wrap_zero", pc, 32'h0);
        branch(16'hFFFE, 1'b1);
        tick();
        check("neg_branch_wrap", pc, 32'hFFFF_FFFF);

        // Randomized control flow, stalls, halts and resets against the model.
        for (int n = 0; n < 4000; n++) begin
            int sel;
            logic [31:0] rc;
            sel = int'($urandom_range(0, 99));
            rc = $urandom;
            if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) rc = m_ras[m_ras.size() - 1];
            if (sel < 30)      drive(6'h20 | 6'($urandom_range(0, 15)), 6'($urandom), 5'($urandom), rc, 26'($urandom), 16'($urandom), 1'b0, 1'($urandom), 1'b0);
            else if (sel < 40) jump(6'h02, 26'($urandom));
            else if (sel < 52) jump(6'h03, 26'($urandom));
            else if (sel < 67) jr(5'd31, rc);
            else if (sel < 72) jr(5'($urandom_range(0, 30)), rc);
            else if (sel < 92) drive(6'h04, 6'h00, 5'd0, rc, 26'h0, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            else if (sel < 93) jump(HALT, 26'($urandom));
            else               drive(6'h00, 6'h20, 5'd31, rc, 26'h0, 16'h0, 1'b1, 1'b0, 1'b0);
            stall = ($urandom_range(0, 4) == 0);
            reset_n = ($urandom_range(0, 49) != 0);
            tick();
        end

        // Stall holds through J and HALT; a released HALT freezes until reset.
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pre_stall_pc", pc, 32'h13);
        jump(6'h02, 26'h99);
        stall = 1'b1;
        tick();
        check("stall_j_pc", pc, 32'h13);
        jump(HALT, 26'h0);
        stall = 1'b1;
        tick();
        check("stall_halt_pc", pc, 32'h13);
        check("stall_halt_flag", 32'(halted), 32'd0);
        stall = 1'b0;
        tick();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", pc, 32'h13);
        for (int i = 0; i < 10; i++) begin
            jump(6'h03, 26'h55);
            tick();
            check("halt_frozen_pc", pc, 32'h13);
            check("halt_ras_empty", 32'(ras_empty), 32'd1);
        end
        reset_n = 1'b0;
        tick();
        check("halt_reset_pc", pc, 32'h10);
        check("halt_reset_flag", 32'(halted), 32'd0);
        reset_n = 1'b1;
        idle();
        tick();
        check("post_reset_pc", pc, 32'h11);
        @(negedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
